// File: rtl/ppu_vram_responder.sv
// VRAM-side responder for the PPU external bus.
// Demultiplexes the ALE-strobed AD bus, applies nametable mirroring, serves
// nametable space from a local CIRAM and forwards pattern space to a CHR port.
module ppu_vram_responder #(
  parameter int CIRAM_AW = 11,
  parameter int CHR_AW   = 13
) (
  input  logic              PCLK,
  input  logic              RES,
  input  logic              ALE,
  input  logic [7:0]        AD_in,
  input  logic [5:0]        PA_hi,
  input  logic              n_RD,
  input  logic              n_WR,
  input  logic [1:0]        MIRR,
  output logic [7:0]        AD_out,
  output logic              AD_oe,
  output logic              chr_req,
  output logic              chr_we,
  output logic [CHR_AW-1:0] chr_addr,
  output logic [7:0]        chr_wdata,
  input  logic              chr_ack,
  input  logic [7:0]        chr_rdata,
  output logic              ERR
);

  typedef enum logic [2:0] {
    IDLE,
    CHR_RD,
    CIRAM_RD,
    DRIVE,
    WR_CAP,
    CHR_WR
  } state_t;

  state_t                state_q;
  logic [13:0]           latAddr_q;
  logic                  nRd_q, nRdDly_q, nWr_q, nWrDly_q;
  logic                  isChr_q;
  logic                  abort_q;
  logic [CIRAM_AW-1:0]   ramIdx_q;
  logic [7:0]            wrData_q;
  logic [7:0]            rdData_q;
  logic [7:0]            adOut_q;
  logic                  adOe_q;
  logic                  chrReq_q;
  logic                  chrWe_q;
  logic [CHR_AW-1:0]     chrAddr_q;
  logic [7:0]            chrWdata_q;
  logic                  err_q;

  logic [7:0]            ciram [0:(2**CIRAM_AW)-1];

  logic                  rdFall, rdRise, wrFall, wrRise;
  logic                  bothLow, anyEdge;
  logic                  mirrBit;
  logic [CIRAM_AW-1:0]   startIdx;
  logic                  startRd, startWr;
  logic                  ramRe, ramWe;

  // Edge detection works on the synchronised strobes, so every edge is seen
  // one cycle after the pin changes.
  assign rdFall  = nRdDly_q & ~nRd_q;
  assign rdRise  = ~nRdDly_q & nRd_q;
  assign wrFall  = nWrDly_q & ~nWr_q;
  assign wrRise  = ~nWrDly_q & nWr_q;
  assign bothLow = ~nRd_q & ~nWr_q;
  assign anyEdge = rdFall | rdRise | wrFall | wrRise;

  // Pick the CIRAM A10 line from the latched address according to the mirroring mode.
  always_comb begin
    mirrBit = 1'b0;
    case (MIRR)
      2'd0:    mirrBit = latAddr_q[11];
      2'd1:    mirrBit = latAddr_q[10];
      2'd2:    mirrBit = 1'b0;
      default: mirrBit = 1'b1;
    endcase
  end

  assign startIdx = {mirrBit, latAddr_q[CIRAM_AW-2:0]};
  assign startRd  = (state_q == IDLE) && rdFall && !ALE && !bothLow;
  assign startWr  = (state_q == IDLE) && wrFall && !ALE && !bothLow;
  assign ramRe    = startRd && latAddr_q[13] && !RES;
  assign ramWe    = (state_q == WR_CAP) && wrRise && !isChr_q && !RES;

  // CIRAM array: no reset so contents survive RES; reads are registered.
  always_ff @(posedge PCLK) begin
    if (ramWe) ciram[ramIdx_q] <= wrData_q;
    if (ramRe) rdData_q <= ciram[startIdx];
  end

  // Strobe sync, address latch, error tracking and the access state machine.
  always_ff @(posedge PCLK) begin
    if (RES) begin
      state_q    <= IDLE;
      latAddr_q  <= '0;
      nRd_q      <= 1'b1;
      nRdDly_q   <= 1'b1;
      nWr_q      <= 1'b1;
      nWrDly_q   <= 1'b1;
      isChr_q    <= 1'b0;
      abort_q    <= 1'b0;
      ramIdx_q   <= '0;
      wrData_q   <= '0;
      adOut_q    <= '0;
      adOe_q     <= 1'b0;
      chrReq_q   <= 1'b0;
      chrWe_q    <= 1'b0;
      chrAddr_q  <= '0;
      chrWdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      nRd_q    <= n_RD;
      nRdDly_q <= nRd_q;
      nWr_q    <= n_WR;
      nWrDly_q <= nWr_q;

      if (ALE) latAddr_q <= {PA_hi, AD_in};
      if (!n_WR) wrData_q <= AD_in;

      if (ALE && (!n_RD || !n_WR)) err_q <= 1'b1;
      if (bothLow) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (startRd) begin
            isChr_q  <= ~latAddr_q[13];
            ramIdx_q <= startIdx;
            if (latAddr_q[13]) begin
              state_q <= CIRAM_RD;
            end else begin
              state_q   <= CHR_RD;
              chrReq_q  <= 1'b1;
              chrWe_q   <= 1'b0;
              chrAddr_q <= latAddr_q[CHR_AW-1:0];
              abort_q   <= 1'b0;
            end
          end else if (startWr) begin
            isChr_q  <= ~latAddr_q[13];
            ramIdx_q <= startIdx;
            if (!latAddr_q[13]) chrAddr_q <= latAddr_q[CHR_AW-1:0];
            state_q  <= WR_CAP;
          end
        end
        CIRAM_RD: begin
          if (rdRise) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            adOut_q <= rdData_q;
            adOe_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        CHR_RD: begin
          if (anyEdge) err_q <= 1'b1;
          if (rdRise) abort_q <= 1'b1;
          if (chr_ack && chrReq_q) begin
            chrReq_q <= 1'b0;
            if (abort_q || rdRise) begin
              state_q <= IDLE;
            end else begin
              adOut_q <= chr_rdata;
              adOe_q  <= 1'b1;
              state_q <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (rdRise) begin
            adOe_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        WR_CAP: begin
          if (wrRise) begin
            if (isChr_q) begin
              chrWdata_q <= wrData_q;
              chrReq_q   <= 1'b1;
              chrWe_q    <= 1'b1;
              state_q    <= CHR_WR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CHR_WR: begin
          if (anyEdge) err_q <= 1'b1;
          if (chr_ack && chrReq_q) begin
            chrReq_q <= 1'b0;
            chrWe_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AD_out    = adOut_q;
  assign AD_oe     = adOe_q;
  assign chr_req   = chrReq_q;
  assign chr_we    = chrWe_q;
  assign chr_addr  = chrAddr_q;
  assign chr_wdata = chrWdata_q;
  assign ERR       = err_q;

endmodule
